// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and helpers for the instruction fetch stage and its branch target buffer.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          PC_STEP  = 4;

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

  // Two-bit saturating branch history counter.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'b00)
      nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered update from branch resolution, valid bits cleared on reset.
module branch_target_buffer
  import instruction_fetch_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_tgt,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - 2 - IDX;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q [ENTRIES];
  logic [XLEN-3:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  // PCs and targets are word aligned, so only word addresses are kept.
  logic [XLEN-3:0] lk_word, up_word, up_tgt_word;
  logic [IDX-1:0]  lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit;

  assign lk_word     = (XLEN-2)'(lookup_pc >> 2);
  assign up_word     = (XLEN-2)'(upd_pc >> 2);
  assign up_tgt_word = (XLEN-2)'(upd_target >> 2);

  assign lk_idx = lk_word[IDX-1:0];
  assign lk_tag = lk_word[XLEN-3:IDX];
  assign up_idx = up_word[IDX-1:0];
  assign up_tag = up_word[XLEN-3:IDX];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign lookup_taken = lk_hit && ctr_q[lk_idx][1];
  assign lookup_tgt   = {tgt_q[lk_idx], 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_update(ctr_q[up_idx], upd_taken);
        if (upd_taken)
          tgt_q[up_idx] <= up_tgt_word;
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= up_tgt_word;
        ctr_q[up_idx]   <= CTR_WEAK_TAKEN;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, next-PC select with BTB prediction, and the IF/ID register.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            IF_ID_write,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            ex_resolve_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_mispredict,
  input  logic [XLEN-1:0] ex_correct_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic            if_id_pred_taken,
  output logic [XLEN-1:0] if_id_pred_tgt
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_seq;
  logic            btb_taken;
  logic [XLEN-1:0] btb_tgt;
  logic [XLEN-1:0] pred_tgt;

  branch_target_buffer #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .lookup_pc    (pc_q),
    .lookup_taken (btb_taken),
    .lookup_tgt   (btb_tgt),
    .upd_valid    (ex_resolve_valid),
    .upd_pc       (ex_pc),
    .upd_taken    (ex_taken),
    .upd_target   (ex_target)
  );

  assign imem_addr = pc_q;
  assign pc_seq    = pc_q + STEP;
  // The predicted next PC travels with the instruction so EX can compare against it.
  assign pred_tgt  = btb_taken ? btb_tgt : pc_seq;

  always_comb begin
    pc_next = pc_q;
    if (ex_mispredict)
      pc_next = ex_correct_pc & ALIGN_MASK;
    else if (!pc_write)
      pc_next = pc_q;
    else
      pc_next = pred_tgt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q             <= RESET_PC;
      if_id_valid      <= 1'b0;
      if_id_pc         <= '0;
      if_id_inst       <= NOP_INST;
      if_id_pred_taken <= 1'b0;
      if_id_pred_tgt   <= '0;
    end else begin
      pc_q <= pc_next;
      if (ex_mispredict) begin
        if_id_valid      <= 1'b0;
        if_id_pc         <= '0;
        if_id_inst       <= NOP_INST;
        if_id_pred_taken <= 1'b0;
        if_id_pred_tgt   <= '0;
      end else if (IF_ID_write) begin
        if_id_valid      <= 1'b1;
        if_id_pc         <= pc_q;
        if_id_inst       <= imem_rdata;
        if_id_pred_taken <= btb_taken;
        if_id_pred_tgt   <= pred_tgt;
      end
    end
  end

endmodule
